// File: rtl/timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and a level interrupt.
// Registers: CTRL, LOAD, COUNT, STATUS, PRESCALE at word offsets 0x00-0x10.
module timer #(
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] per_addr_i,
  input  logic [31:0]       per_data_i,
  input  logic              sel_i,
  input  logic              we_i,
  output logic [31:0]       tim_data_o,
  output logic              irq_o
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_LOAD     = 3'd1;
  localparam logic [2:0] A_COUNT    = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_PRESCALE = 3'd4;

  logic             en;
  logic             auto_rl;
  logic             ie;
  logic             exp;
  logic [31:0]      load_r;
  logic [31:0]      count;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;

  logic [2:0]  reg_sel;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic        wr_prescale;
  logic        tick;
  logic        expire;
  logic [31:0] prescale_ext;
  logic        unused_addr;

  // Saturating decrement: COUNT never wraps below zero.
  function automatic logic [31:0] dec_sat(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  assign reg_sel     = per_addr_i[4:2];
  assign unused_addr = ^{per_addr_i[ADDR_W-1:5], per_addr_i[1:0]};

  assign wr          = sel_i & we_i;
  assign wr_ctrl     = wr & (reg_sel == A_CTRL);
  assign wr_load     = wr & (reg_sel == A_LOAD);
  assign wr_status   = wr & (reg_sel == A_STATUS);
  assign wr_prescale = wr & (reg_sel == A_PRESCALE);

  // Tick and expiry are derived from pre-write register state.
  assign tick   = en & (pre_cnt == prescale);
  assign expire = tick & (count == 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      exp      <= 1'b0;
      load_r   <= 32'd0;
      count    <= 32'd0;
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (!en || tick) pre_cnt <= '0;
      else             pre_cnt <= pre_cnt + PRE_W'(1);

      // Software CTRL write outranks the hardware one-shot EN clear.
      if (wr_ctrl) begin
        en      <= per_data_i[0];
        auto_rl <= per_data_i[1];
        ie      <= per_data_i[2];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end

      if (wr_load) load_r <= per_data_i;

      if (wr_load)                 count <= per_data_i;
      else if (expire && auto_rl)  count <= load_r;
      else if (tick)               count <= dec_sat(count);

      // Hardware set outranks the write-1-clear.
      if (expire)                          exp <= 1'b1;
      else if (wr_status && per_data_i[0]) exp <= 1'b0;

      if (wr_prescale) prescale <= per_data_i[PRE_W-1:0];
    end
  end

  assign irq_o = exp & ie;

  always_comb begin
    prescale_ext              = 32'd0;
    prescale_ext[PRE_W-1:0]   = prescale;
    tim_data_o                = 32'd0;
    if (sel_i) begin
      case (reg_sel)
        A_CTRL:     tim_data_o = {29'd0, ie, auto_rl, en};
        A_LOAD:     tim_data_o = load_r;
        A_COUNT:    tim_data_o = count;
        A_STATUS:   tim_data_o = {31'd0, exp};
        A_PRESCALE: tim_data_o = prescale_ext;
        default:    tim_data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter PRE_W, default 16, sets the prescaler register and counter width in bits (range 1..32).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 per_addr_i  input  `mem_addr_bus`  peripheral address from the bus; only bits [4:2] are decoded.
REQ-005 per_data_i  input  `data_bus` (32)  write data from the bus.
REQ-006 sel_i  input  1  timer chip select from the bus address decode.
REQ-007 we_i  input  1  write strobe; a write occurs when sel_i=1 and we_i=1 on a clock edge.
REQ-008 tim_data_o  output  `data_bus` (32)  read data, consumed by the bus as tim_data_i.
REQ-009 irq_o  output  1  timer interrupt request, level-sensitive.

Function
REQ-010 Register map (word offsets) shall be:
- 0x00 CTRL (RW): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); other bits read 0.
- 0x04 LOAD (RW, 32b).
- 0x08 COUNT (RO; writes ignored).
- 0x0C STATUS: bit0 EXP; write 1 clears, write 0 has no effect.
- 0x10 PRESCALE (RW, low PRE_W bits).
- Offsets 0x14-0x1C read 0; writes to them are ignored.
REQ-011 tim_data_o shall be combinational from per_addr_i[4:2] and current register state, with zero wait states.
REQ-012 tim_data_o shall be 0 when sel_i=0.
REQ-013 Register writes shall take effect on the clock edge they are sampled; the new value shall be visible on a read in the following cycle.
REQ-014 A write to LOAD shall also load COUNT with the written value on the same edge, overriding any decrement in that cycle.
REQ-015 Prescaler counter pre_cnt shall increment each cycle while EN=1.
REQ-016 When pre_cnt==PRESCALE, a tick shall be produced and pre_cnt shall return to 0, giving a tick period of PRESCALE+1 cycles.
REQ-017 While EN=0, pre_cnt shall be held at 0.
REQ-018 On a tick with COUNT!=0, COUNT shall decrement by 1.
REQ-019 On a tick with COUNT==0:
- EXP shall be set.
- If AUTO=1, COUNT shall be set to LOAD.
- If AUTO=0, COUNT shall stay 0 and EN shall be cleared by hardware.
REQ-020 With LOAD=0 and AUTO=1, EXP shall be set on every tick.
REQ-021 irq_o shall equal EXP & IE, registered state only, with no combinational path from inputs.
REQ-022 If a hardware EXP set and a software write-1-clear of EXP occur in the same cycle, the set shall win and EXP shall remain 1.
REQ-023 If a CTRL write and a tick occur in the same cycle, the tick shall use the pre-write EN/AUTO values.
REQ-024 If a CTRL write and a hardware EN clear occur in the same cycle, the software write shall win.
REQ-025 COUNT arithmetic shall be 32-bit unsigned and shall never wrap below 0.

Reset
REQ-026 On a clock edge with rst_n=0, CTRL, LOAD, COUNT, STATUS, PRESCALE and pre_cnt shall all be set to 0.
REQ-027 During and after reset, irq_o shall be 0 and tim_data_o shall be 0 for all reads until registers are written.
REQ-028 Reset asserted mid-count shall abort the count with no EXP set; software shall re-write registers to restart.

Verification
REQ-029 Reset then read offsets 0x00-0x1C -> all reads return 0; irq_o=0.
REQ-030 Write PRESCALE=0, LOAD=3, CTRL=0x7 -> COUNT reads 3,2,1,0 on successive cycles; next cycle EXP=1, irq_o=1, COUNT=3.
REQ-031 One-shot: PRESCALE=4, LOAD=2, CTRL=0x1 -> EXP sets 15 cycles after the CTRL write; EN then reads 0; COUNT holds 0; irq_o stays 0 (IE=0).
REQ-032 With EXP=1 and a tick expiring in the same cycle as a write of 0x1 to STATUS -> EXP reads 1.
REQ-033 With EXP=1 and no expiry, write 0x1 to STATUS -> EXP reads 0 and irq_o falls the next cycle.
REQ-034 Mid-count (COUNT=5), pulse rst_n low for 1 cycle -> all registers 0, irq_o=0, and no further decrements occur.
